// File: rtl/bus_mem_target.sv
// Memory-mapped 32-bit word target on the shared DSP bus.
// Claims addresses in its window, then completes one data transfer per frame with TRDY_B.
module bus_mem_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [31:0] AD,
    input  logic        FRAME_B,
    input  logic        IRDY_B,
    input  logic        CMD,
    output wire         TRDY_B
);
    typedef enum logic [2:0] {S_IDLE, S_TURN, S_DATA, S_DONE, S_SKIP} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              cmd_q;
    logic [3:0]        cnt_q;
    logic [31:0]       ad_out_q;
    logic              ad_oe_q;
    logic              trdy_q;
    logic              trdy_oe_q;
    logic [31:0]       mem_q [2**ADDR_W];

    logic frame_act;
    logic irdy_act;
    logic hit;
    logic mem_we;
    logic unused_ad;

    // Only a clean 0 counts as asserted; z/x from a released line reads as idle.
    assign frame_act = (FRAME_B == 1'b0);
    assign irdy_act  = (IRDY_B == 1'b0);
    assign hit       = (AD[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign unused_ad = ^AD[1:0];

    assign mem_we = !RST && (state_q == S_DATA) && irdy_act && (cnt_q == 4'd0) && cmd_q;

    assign AD     = ad_oe_q   ? ad_out_q : 32'bz;
    assign TRDY_B = trdy_oe_q ? trdy_q   : 1'bz;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cmd_q     <= 1'b0;
            cnt_q     <= 4'd0;
            ad_out_q  <= '0;
            ad_oe_q   <= 1'b0;
            trdy_q    <= 1'b1;
            trdy_oe_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_act && !irdy_act) begin
                        idx_q <= AD[ADDR_W+1:2];
                        cmd_q <= CMD;
                        if (hit) begin
                            state_q   <= S_TURN;
                            trdy_q    <= 1'b1;
                            trdy_oe_q <= 1'b1;
                        end else begin
                            state_q <= S_SKIP;
                        end
                    end
                end
                S_TURN: begin
                    // The master has stopped driving the address by now, so read data may go out.
                    if (!cmd_q) begin
                        ad_out_q <= mem_q[idx_q];
                        ad_oe_q  <= 1'b1;
                    end
                    cnt_q   <= 4'(WAIT_STATES);
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    if (irdy_act) begin
                        if (cnt_q != 4'd0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end else begin
                            trdy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    trdy_q    <= 1'b1;
                    trdy_oe_q <= 1'b0;
                    ad_oe_q   <= 1'b0;
                    state_q   <= S_IDLE;
                end
                S_SKIP: begin
                    if (!frame_act) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Storage is outside the reset domain so contents survive RST.
    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[idx_q] <= AD;
    end
endmodule

// File: doc/bus_mem_target.md
Name: bus_mem_target

Overview:
- Memory-mapped target on the shared DSP bus.
- Sits directly downstream of the DSP bus masters (the requesters that own REQ_B/GNT_B/FRAME_B/IRDY_B).
- Decodes each master transaction, stores write data into a local 32-bit word array, returns read data on AD, and completes the transfer by asserting TRDY_B.
- Multiple instances share the bus. Each one drives AD and TRDY_B only while it is selected.

Parameters:
BASE_ADDR  32'h0000_0000  byte base address; must be aligned to 2^(ADDR_W+2)
ADDR_W  8  log2 of word count (256 x 32-bit words)
WAIT_STATES  0  extra data-phase cycles before TRDY_B assertion (0..15)

Ports:
CLK  input  1  bus clock; all logic on posedge
RST  input  1  synchronous, active-high reset
AD  inout  32  multiplexed address/data; driven only for read data
FRAME_B  input  1  transaction frame, active low
IRDY_B  input  1  master ready, active low
CMD  input  1  sampled with address: 0 = read, 1 = write
TRDY_B  output  1  target ready, active low; high-Z when not selected

Interface: one clock CLK; reset RST is synchronous and active-high.

Behaviour:
- Signal sampling:
  - Bus control inputs count as asserted only when sampled 1'b0.
  - z, x and 1 all count as deasserted. The bench provides pull-ups on FRAME_B, IRDY_B and TRDY_B.
- Reset (RST=1 at posedge):
  - state=IDLE, AD released (z), TRDY_B=z, wait counter=0.
  - Memory contents are unaffected.
  - Reset mid-transaction aborts the transfer: no memory write, bus released on that edge.
- Address decode:
  - hit = (AD[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
  - index = AD[ADDR_W+1:2]. AD[1:0] is ignored.
- States:
  - IDLE: on posedge with FRAME_B=0 and IRDY_B not asserted:
    - Latch index and CMD.
    - hit → TURN, and drive TRDY_B=1 (take ownership).
    - miss → SKIP.
  - TURN: exactly one cycle; AD turnaround.
    - On exit edge: if read, AD_out<=mem[index] and AD output enable<=1.
    - Load counter=WAIT_STATES → DATA.
  - DATA: at each posedge:
    - IRDY_B not asserted: hold.
    - IRDY_B=0 and counter≠0: decrement.
    - IRDY_B=0 and counter=0: if write, mem[index]<=AD; TRDY_B<=0; → DONE.
  - DONE: one cycle. At next posedge TRDY_B<=z, AD released → IDLE.
  - SKIP: stay until a posedge samples FRAME_B deasserted → IDLE.
- Latency:
  - Address edge T0, TURN edge T1.
  - Earliest TRDY_B=0 at T2+WAIT_STATES, when IRDY_B is sampled low at T2.
- Read data is stable on AD from T1 through the DONE edge, so it is valid before and while TRDY_B is low.
- AD is never driven at T0 or T1-before-edge. This prevents contention with the master's address drive.
- TRDY_B is low for exactly one cycle per transfer.
- Back-to-back transfers:
  - A new FRAME_B=0 sampled in the cycle immediately after DONE is accepted normally.
  - FRAME_B sampled low while in TURN/DATA/DONE is treated as part of the current transfer, never as a new address.
- Misses never drive AD or TRDY_B.
- CMD is latched only at the address edge; later changes on CMD are ignored.

Test Plan:
- Single write then read, ADDR_W=8, BASE=0, WAIT_STATES=0:
  - Write addr 32'h10, data 32'hDEAD_BEEF, then read 32'h10.
  - Required: TRDY_B low exactly 1 cycle at T2 each time; master read returns 32'hDEAD_BEEF; AD z outside T1..DONE on the read.
- Wait states, WAIT_STATES=3:
  - Read 32'h04.
  - Required: TRDY_B falls at T5 (3 cycles after IRDY_B sampled low at T2); AD holds mem[1] from T1 to DONE edge.
- Address miss, BASE=32'h0000_1000:
  - Write 32'h0000_0020.
  - Required: TRDY_B and AD stay z for the whole frame; block returns to IDLE when FRAME_B releases; a subsequent hit at 32'h0000_1020 completes normally.
- Two instances, BASE 32'h0 and 32'h400:
  - Interleaved writes 32'h4=1, 32'h404=2, then reads.
  - Required: returns 1 and 2; only the addressed instance ever drives TRDY_B.
- Reset mid-transfer, WAIT_STATES=4:
  - Write 32'h8=32'h5555_5555 with RST=1 asserted during DATA.
  - Required: TRDY_B and AD z on the reset edge; state IDLE; later read of 32'h8 returns the old value.
- Index wrap, ADDR_W=8:
  - Write 32'h3FC=32'hA5A5_A5A5 and 32'h0=32'h1.
  - Required: reads return those values independently; the 32'h3FC write does not alias index 0.
